fir_l2_stream_ctrl: RTL and testbench
=====================================

// Module: fir_l2_stream_ctrl
// PURPOSE
//  Sequencer for the 2-parallel (L2) FIR filter top.
//  - Accepts a serial 16-bit sample stream (valid/ready).
//  - Pairs samples: x[2k] -> fir_data_in_1, x[2k+1] -> fir_data_in_2.
//  - Advances the filter with fir_en and tracks in-flight pairs.
//  - Re-serialises data_out_1/data_out_2 into one output stream with backpressure.
// PARAMETERS
//  IN_W         16  input sample width (matches filter data_in)
//  FIR_OUT_W    64  filter output width
//  OUT_W        24  output stream width
//  OUT_SHIFT    23  arithmetic right shift applied to filter output before narrowing
//  FIR_LATENCY   3  fir_en advances from pair presented to matching pair on data_out (>=1)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  s_valid        in   1          input sample valid
//  s_data         in   IN_W       input sample, signed
//  s_ready        out  1          input accept; transfer when s_valid&&s_ready
//  flush          in   1          1-cycle pulse: drain pipeline with zero pairs
//  flush_busy     out  1          flush in progress
//  fir_en         out  1          filter clock-enable (one advance per high cycle)
//  fir_data_in_1  out  IN_W       even sample to filter
//  fir_data_in_2  out  IN_W       odd sample to filter
//  fir_data_out_1 in   FIR_OUT_W  filter even output
//  fir_data_out_2 in   FIR_OUT_W  filter odd output
//  m_valid        out  1          output sample valid
//  m_data         out  OUT_W      output sample, signed, even before odd
//  m_ready        in   1          output accept
//  ovf_sticky     out  1          saturation occurred (FIR_CTRL_SAT_EN only; else tied 0)
// BEHAVIOUR
//  Reset: all outputs 0; s_ready 0 in the reset cycle, 1 on the first cycle after.
//  - Pair FSM, one register each for the even and odd samples:
//    - P_EVEN: accepting x[2k]; on transfer -> P_ODD.
//    - P_ODD: accepting x[2k+1]; on transfer -> P_FULL.
//    - P_FULL: s_ready=0, pair presented on fir_data_in_*.
//    - On fir_en: -> P_EVEN and same-cycle s_ready=1 (bubble-free streaming).
//  - Valid pipe: FIR_LATENCY-bit shift register, shifted only on fir_en.
//    - Shift-in 1 for a real pair, 0 for a flush pair.
//    - tail = bit[FIR_LATENCY-1].
//  - fir_en = pair_avail && out_free.
//    - pair_avail = P_FULL, or flush_busy (zero pair).
//    - out_free = out FSM in O_EMPTY, or O_ODD with m_ready, or tail==0.
//  - Out FSM:
//    - O_EMPTY: on fir_en with tail=1, capture both narrowed outputs -> O_EVEN.
//    - O_EVEN: m_valid=1, m_data=even; on m_ready -> O_ODD.
//    - O_ODD: m_data=odd; on m_ready -> O_EMPTY, or reload O_EVEN if fir_en&&tail.
//    - m_data and m_valid are stable while m_valid && !m_ready.
//  - Narrowing: y >>> OUT_SHIFT (arithmetic), then take low OUT_W bits (truncate/wrap).
//  - Flush (flush pulse ignored if already busy):
//    - If in P_ODD, zero-pad the odd slot and present the pair as real (valid bit 1).
//    - Then issue zero pairs until the valid pipe is all 0; flush_busy drops the next cycle.
//    - s_ready=0 while flush_busy.
//    - Flush in P_EVEN with empty pipe: flush_busy high for exactly 1 cycle.
//  - Simultaneous: flush with an s_data transfer in P_ODD -> the sample is taken as odd; no pad.
//  - Reset mid-stream discards held pairs, the valid pipe and the output register.
//    The filter's own state is not cleared by this block.
// CONFIGURATION
//  FIR_CTRL_SAT_EN defined:
//    - after the shift, clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
//    - ovf_sticky sets on any clamp of a captured real output; cleared only by reset.
//  Undefined: truncation as above; ovf_sticky tied 0.
// STRUCTURE
//  Package fir_l2_ctrl_pkg:
//    - pair_state_t {P_EVEN,P_ODD,P_FULL}, out_state_t {O_EMPTY,O_EVEN,O_ODD};
//    - default width constants;
//    - narrow() function (shift + truncate/saturate).
//  Sub-module fir_l2_valid_pipe: enable-gated valid shift register; outputs tail and any_valid.
// TESTING (FIR_LATENCY=3, OUT_SHIFT=0)
//  1. Reset 2 cycles -> m_valid=0, fir_en=0, s_ready=1 after the reset cycle.
//  2. Stream 1,2,3,...,8, m_ready=1 -> fir_en pulses once per 2 samples;
//     m_data order matches filter out_1,out_2 per pair, no loss or duplication.
//  3. m_ready=0 for 10 cycles mid-stream:
//     - m_data held;
//     - fir_en low once out register full and tail=1;
//     - s_ready=0 once P_FULL;
//     - resume yields the exact sequence.
//  4. Send 5 samples, then pulse flush ->
//     - x[5] paired with 0;
//     - 3 outputs pairs = 6 samples emitted;
//     - flush_busy falls after valid pipe empty; pipe emptying needs 3 advances.
//  5. Feed filter outputs of 2^40 with OUT_W=24:
//     - SAT_EN -> m_data=0x7FFFFF, ovf_sticky=1;
//     - no macro -> m_data=0x000000, ovf_sticky=0.
//  6. Assert reset during O_EVEN with P_ODD held ->
//     - next cycle m_valid=0, pair FSM P_EVEN;
//     - new stream outputs only post-reset pairs.

Source files
------------

// File: rtl/fir_l2_ctrl_pkg.sv
// rtl/fir_l2_ctrl_pkg.sv - shared states, default widths and output narrowing for the L2 FIR sequencer
package fir_l2_ctrl_pkg;

    localparam int IN_W_DEF        = 16;
    localparam int FIR_OUT_W_DEF   = 64;
    localparam int OUT_W_DEF       = 24;
    localparam int OUT_SHIFT_DEF   = 23;
    localparam int FIR_LATENCY_DEF = 3;

    typedef enum logic [1:0] {
        P_EVEN,
        P_ODD,
        P_FULL
    } pair_state_t;

    typedef enum logic [1:0] {
        O_EMPTY,
        O_EVEN,
        O_ODD
    } out_state_t;

    // Arithmetic shift, then optional clamp to the signed out_w range; caller keeps the low out_w bits.
    function automatic logic [63:0] narrow(input logic signed [63:0] y, input int shift,
                                           input int out_w, input logic sat);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = y >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (sat && (s > hi)) begin
            return hi;
        end
        if (sat && (s < lo)) begin
            return lo;
        end
        return s;
    endfunction

    function automatic logic clamps(input logic signed [63:0] y, input int shift, input int out_w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = y >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/fir_l2_valid_pipe.sv
// rtl/fir_l2_valid_pipe.sv - enable-gated valid shift register tracking pairs inside the filter
module fir_l2_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic bit_i,
    output logic tail_o,
    output logic any_valid_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (en_i) begin
            pipe_d = DEPTH'({pipe_q, bit_i});
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail_o      = pipe_q[DEPTH-1];
    assign any_valid_o = |pipe_q;

endmodule

// File: rtl/fir_l2_stream_ctrl.sv
// rtl/fir_l2_stream_ctrl.sv - pairs a serial sample stream into the L2 FIR and re-serialises its outputs
// Optional saturation of the narrowed outputs is enabled by defining FIR_CTRL_SAT_EN.
module fir_l2_stream_ctrl
    import fir_l2_ctrl_pkg::*;
#(
    parameter int IN_W        = IN_W_DEF,
    parameter int FIR_OUT_W   = FIR_OUT_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int OUT_SHIFT   = OUT_SHIFT_DEF,
    parameter int FIR_LATENCY = FIR_LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [IN_W-1:0]      s_data,
    output logic                 s_ready,
    input  logic                 flush,
    output logic                 flush_busy,
    output logic                 fir_en,
    output logic [IN_W-1:0]      fir_data_in_1,
    output logic [IN_W-1:0]      fir_data_in_2,
    input  logic [FIR_OUT_W-1:0] fir_data_out_1,
    input  logic [FIR_OUT_W-1:0] fir_data_out_2,
    output logic                 m_valid,
    output logic [OUT_W-1:0]     m_data,
    input  logic                 m_ready,
    output logic                 ovf_sticky
);

`ifdef FIR_CTRL_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    pair_state_t       pair_q, pair_d;
    out_state_t        out_q, out_d;
    logic [IN_W-1:0]   even_q, even_d;
    logic [IN_W-1:0]   odd_q, odd_d;
    logic              flush_busy_q, flush_busy_d;
    logic [OUT_W-1:0]  y_even_q, y_even_d;
    logic [OUT_W-1:0]  y_odd_q, y_odd_d;
    logic signed [63:0] y_even_ext;
    logic signed [63:0] y_odd_ext;

    logic tail;
    logic any_valid;
    logic pair_avail;
    logic out_free;
    logic cap;
    logic s_fire;
    logic flush_start;

    assign y_even_ext = 64'($signed(fir_data_out_1));
    assign y_odd_ext  = 64'($signed(fir_data_out_2));

    // Zero pairs are only issued while something real is still inside the filter.
    always_comb begin
        pair_avail  = (pair_q == P_FULL) || (flush_busy_q && any_valid);
        out_free    = (out_q == O_EMPTY) || ((out_q == O_ODD) && m_ready) || !tail;
        fir_en      = !reset && pair_avail && out_free;
        s_ready     = !reset && !flush_busy_q && ((pair_q != P_FULL) || fir_en);
        s_fire      = s_valid && s_ready;
        flush_start = flush && !flush_busy_q;
        cap         = fir_en && tail;
    end

    always_comb begin
        pair_d       = pair_q;
        even_d       = even_q;
        odd_d        = odd_q;
        flush_busy_d = flush_busy_q;
        if (fir_en && (pair_q == P_FULL)) begin
            pair_d = P_EVEN;
        end
        if (s_fire) begin
            if (pair_d == P_EVEN) begin
                even_d = s_data;
                pair_d = P_ODD;
            end else begin
                odd_d  = s_data;
                pair_d = P_FULL;
            end
        end
        // A half-filled pair at flush time is completed with a zero odd sample and kept as real data.
        if (flush_start) begin
            flush_busy_d = 1'b1;
            if (pair_d == P_ODD) begin
                odd_d  = '0;
                pair_d = P_FULL;
            end
        end else if (flush_busy_q && (pair_q != P_FULL) && !any_valid) begin
            flush_busy_d = 1'b0;
        end
    end

    always_comb begin
        out_d    = out_q;
        y_even_d = y_even_q;
        y_odd_d  = y_odd_q;
        if (cap) begin
            y_even_d = OUT_W'(narrow(y_even_ext, OUT_SHIFT, OUT_W, SAT_EN));
            y_odd_d  = OUT_W'(narrow(y_odd_ext, OUT_SHIFT, OUT_W, SAT_EN));
        end
        case (out_q)
            O_EMPTY: begin
                if (cap) begin
                    out_d = O_EVEN;
                end
            end
            O_EVEN: begin
                if (m_ready) begin
                    out_d = O_ODD;
                end
            end
            O_ODD: begin
                if (m_ready) begin
                    out_d = cap ? O_EVEN : O_EMPTY;
                end
            end
            default: out_d = O_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pair_q       <= P_EVEN;
            out_q        <= O_EMPTY;
            even_q       <= '0;
            odd_q        <= '0;
            flush_busy_q <= 1'b0;
            y_even_q     <= '0;
            y_odd_q      <= '0;
        end else begin
            pair_q       <= pair_d;
            out_q        <= out_d;
            even_q       <= even_d;
            odd_q        <= odd_d;
            flush_busy_q <= flush_busy_d;
            y_even_q     <= y_even_d;
            y_odd_q      <= y_odd_d;
        end
    end

    fir_l2_valid_pipe #(
        .DEPTH (FIR_LATENCY)
    ) u_valid_pipe (
        .clk_i       (clk),
        .reset_i     (reset),
        .en_i        (fir_en),
        .bit_i       (pair_q == P_FULL),
        .tail_o      (tail),
        .any_valid_o (any_valid)
    );

    assign flush_busy    = flush_busy_q;
    assign fir_data_in_1 = (pair_q == P_FULL) ? even_q : '0;
    assign fir_data_in_2 = (pair_q == P_FULL) ? odd_q : '0;
    assign m_valid       = (out_q != O_EMPTY);
    assign m_data        = (out_q == O_EVEN) ? y_even_q :
                           (out_q == O_ODD)  ? y_odd_q  : '0;

`ifdef FIR_CTRL_SAT_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (cap && (clamps(y_even_ext, OUT_SHIFT, OUT_W) || clamps(y_odd_ext, OUT_SHIFT, OUT_W))) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_sticky = ovf_q;
`else
    assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fir_l2_stream_ctrl.sv
// tb/tb_fir_l2_stream_ctrl.sv - scoreboard bench for fir_l2_stream_ctrl with a behavioural 3-deep filter
module tb_fir_l2_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        flush = 1'b0;
    logic        flush_busy;
    logic        fir_en;
    logic [15:0] fir_data_in_1;
    logic [15:0] fir_data_in_2;
    logic [63:0] fir_data_out_1;
    logic [63:0] fir_data_out_2;
    logic        m_valid;
    logic [23:0] m_data;
    logic        m_ready = 1'b1;
    logic        ovf_sticky;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int busy_en = 0;
    int busy_cyc = 0;
    int n_out = 0;
    bit parity = 1'b0;
    logic [23:0] exp_q[$];

    logic [63:0] st1a = '0, st1b = '0, st2a = '0, st2b = '0, st3a = '0, st3b = '0;

    logic [15:0] v3 [12] = '{16'd9, 16'hFFFF, 16'd1000, 16'h8000, 16'h7FFF, 16'd14,
                             16'd15, 16'hFFF0, 16'd17, 16'd18, 16'd19, 16'd20};
    logic [15:0] v4 [5]  = '{16'd21, 16'hFFF0, 16'd23, 16'd24, 16'd25};

    fir_l2_stream_ctrl #(
        .IN_W        (16),
        .FIR_OUT_W   (64),
        .OUT_W       (24),
        .OUT_SHIFT   (0),
        .FIR_LATENCY (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .flush          (flush),
        .flush_busy     (flush_busy),
        .fir_en         (fir_en),
        .fir_data_in_1  (fir_data_in_1),
        .fir_data_in_2  (fir_data_in_2),
        .fir_data_out_1 (fir_data_out_1),
        .fir_data_out_2 (fir_data_out_2),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .ovf_sticky     (ovf_sticky)
    );

    always #5 clk = ~clk;

    // Filter stand-in: y = 3*x, except 0x4000 which yields 2^40.
    function automatic logic [63:0] f64(input logic [15:0] x);
        if (x == 16'h4000) begin
            return 64'h0000_0100_0000_0000;
        end
        return 64'($signed(x)) * 64'd3;
    endfunction

    function automatic logic [23:0] exp_of(input logic [15:0] x);
        longint v;
        if (x == 16'h4000) begin
`ifdef FIR_CTRL_SAT_EN
            return 24'h7FFFFF;
`else
            return 24'h000000;
`endif
        end
        v = longint'($signed(x)) * 3;
        return v[23:0];
    endfunction

    always @(posedge clk) begin
        if (fir_en) begin
            st1a <= f64(fir_data_in_1);
            st1b <= f64(fir_data_in_2);
            st2a <= st1a;
            st2b <= st1b;
            st3a <= st2a;
            st3b <= st2b;
        end
    end
    assign fir_data_out_1 = st3a;
    assign fir_data_out_2 = st3b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = x;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", {63'd0, s_ready}, 64'd1);
        if (s_ready) begin
            exp_q.push_back(exp_of(x));
            parity = ~parity;
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic do_flush();
        if (parity) begin
            exp_q.push_back(exp_of(16'd0));
            parity = 1'b0;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (flush_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("flush_done", {63'd0, flush_busy}, 64'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Monitor: scoreboard pops, hold-stability and event counters.
    initial begin
        logic        hold_pending;
        logic [23:0] hold_data;
        logic [23:0] e;
        hold_pending = 1'b0;
        hold_data    = '0;
        forever begin
            @(negedge clk);
            if (fir_en) en_cnt++;
            if (fir_en && flush_busy) busy_en++;
            if (flush_busy) busy_cyc++;
            if (flush_busy) chk("s_ready_while_busy", {63'd0, s_ready}, 64'd0);
            if (!reset && m_valid) begin
                if (hold_pending) chk("m_data_hold", 64'(m_data), 64'(hold_data));
                if (m_ready) begin
                    hold_pending = 1'b0;
                    n_out++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", 64'(m_data), 64'(e));
                    end
                end else begin
                    hold_pending = 1'b1;
                    hold_data    = m_data;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int o0;

        // 1: reset
        @(negedge clk);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_fir_en", {63'd0, fir_en}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("post_rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("post_rst_busy", {63'd0, flush_busy}, 64'd0);
        chk("post_rst_ovf", {63'd0, ovf_sticky}, 64'd0);
        tick();

        // 2: stream 1..8 with free output
        c0 = en_cnt;
        o0 = n_out;
        for (int i = 1; i <= 8; i++) send(16'(i));
        tick();
        tick();
        chk("stream_fir_en_count", 64'(en_cnt - c0), 64'd4);
        do_flush();
        wait_idle();
        wait_drain();
        chk("stream_out_count", 64'(n_out - o0), 64'd8);

        // 3: output stall mid-stream
        m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) send(v3[i]);
            end
            begin
                repeat (14) @(posedge clk);
                @(negedge clk);
                chk("stall_fir_en", {63'd0, fir_en}, 64'd0);
                chk("stall_s_ready", {63'd0, s_ready}, 64'd0);
                chk("stall_m_valid", {63'd0, m_valid}, 64'd1);
                tick();
                m_ready = 1'b1;
            end
        join
        do_flush();
        wait_idle();
        wait_drain();

        // 4: odd sample count then flush
        o0 = n_out;
        for (int i = 0; i < 5; i++) send(v4[i]);
        busy_en = 0;
        do_flush();
        wait_idle();
        wait_drain();
        chk("flush_pad_advances", 64'(busy_en), 64'd4);
        chk("flush_pad_out_count", 64'(n_out - o0), 64'd6);

        // flush with nothing in flight
        busy_en  = 0;
        busy_cyc = 0;
        do_flush();
        repeat (3) tick();
        chk("empty_flush_cycles", 64'(busy_cyc), 64'd1);
        chk("empty_flush_fir_en", 64'(busy_en), 64'd0);
        chk("ovf_before_big", {63'd0, ovf_sticky}, 64'd0);

        // 5: oversize filter output
        send(16'h4000);
        send(16'h4000);
        do_flush();
        wait_idle();
        wait_drain();
`ifdef FIR_CTRL_SAT_EN
        chk("ovf_sticky", {63'd0, ovf_sticky}, 64'd1);
`else
        chk("ovf_sticky", {63'd0, ovf_sticky}, 64'd0);
`endif

        // 6: reset with output held and a half pair
        m_ready = 1'b0;
        for (int i = 101; i <= 109; i++) send(16'(i));
        @(negedge clk);
        chk("pre_rst_m_valid", {63'd0, m_valid}, 64'd1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        parity = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("mid_rst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("mid_rst_ovf", {63'd0, ovf_sticky}, 64'd0);
        tick();
        m_ready = 1'b1;
        o0 = n_out;
        for (int i = 111; i <= 114; i++) send(16'(i));
        do_flush();
        wait_idle();
        wait_drain();
        chk("post_rst_out_count", 64'(n_out - o0), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
